// File: rtl/alu_pipe.sv
// alu_pipe: registered valid/ready ALU with flags; ALU_PIPE_MUL_EN enables the iterative multiplier for opcode 11.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_co,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic             accept, is_mul, mul_done, sub, cout, ovf_raw, co, ovf, err;
    logic [WIDTH-1:0] bx, sum, res, mul_res;
    logic [SHW-1:0]   sh;
    assign accept = in_valid && in_ready;
    assign sh     = in_b[SHW-1:0];
    // SUB reuses the adder as a + ~b + 1, so co is the inverse of borrow
    assign sub    = in_op == 4'd5;
    assign bx     = sub ? ~in_b : in_b;
    assign {cout, sum} = {1'b0, in_a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub | in_ci};
    assign ovf_raw = (in_a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    always_comb begin
        res = '0;
        co  = 1'b0;
        ovf = 1'b0;
        case (in_op)
            4'd0:       res = in_a & in_b;
            4'd1:       res = in_a | in_b;
            4'd2:       res = in_a ^ in_b;
            4'd3:       res = ~in_a;
            4'd4, 4'd5: begin
                res = sum;
                co  = cout;
                ovf = ovf_raw;
            end
            4'd6:       res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd7:       res = {{(WIDTH-1){1'b0}}, in_a < in_b};
            4'd8:       res = in_a << sh;
            4'd9:       res = in_a >> sh;
            4'd10:      res = $signed(in_a) >>> sh;
            default:    res = '0;
        endcase
        err = (in_op >= 4'd12) || (in_op == 4'd11 && !MUL_EN);
    end
`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [SHW-1:0]   cnt;
    assign is_mul   = in_op == 4'd11;
    assign mul_res  = acc + (mplier[0] ? mcand : '0);
    assign mul_done = state == MUL && cnt == '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (accept && is_mul) ? MUL : IDLE;
            MUL:     state_nx = (cnt == '0) ? IDLE : MUL;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy     = state == MUL;
        in_ready = state == IDLE && (!out_valid || out_ready);
    end
    // Shift-and-add: one multiplier bit per cycle, WIDTH cycles total
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && accept && is_mul) begin
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= '0;
            cnt    <= SHW'(WIDTH-1);
        end else if (state == MUL) begin
            acc    <= mul_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
`else
    assign is_mul   = 1'b0;
    assign mul_res  = '0;
    assign mul_done = 1'b0;
    assign busy     = 1'b0;
    assign in_ready = !out_valid || out_ready;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_co     <= 1'b0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            out_result <= mul_res;
            out_co     <= 1'b0;
            out_zero   <= mul_res == '0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid  <= 1'b1;
            out_result <= res;
            out_co     <= co;
            out_zero   <= res == '0;
            out_ovf    <= ovf;
            out_err    <= err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe; expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ci = 1'b0, out_ready = 1'b1;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_op = '0;
    logic        in_ready, out_valid, out_co, out_zero, out_ovf, out_err, busy;
    logic [31:0] out_result;
    int          errors = 0, checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_co(out_co), .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci);
        in_op = op; in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({out_valid, busy, out_err, out_co, out_zero, out_ovf} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {out_valid, busy, out_err, out_co, out_zero, out_ovf}); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", out_result); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add();
        drive(4'd4, 32'hFFFF_FFFF, 32'h1, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL add_result got %h exp 00000000", out_result); end
        checks++; if ({out_co, out_zero, out_ovf, out_err} !== 4'b1100) begin errors++; $display("FAIL add_flags got %b exp 1100", {out_co, out_zero, out_ovf, out_err}); end
        drive(4'd4, 32'h7FFF_FFFF, 32'h0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++; if ({out_result, out_co, out_ovf} !== {32'h8000_0000, 2'b01}) begin errors++; $display("FAIL add_ci_ovf got %h co=%b ovf=%b exp 80000000 co=0 ovf=1", out_result, out_co, out_ovf); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(4'd5, 32'h8000_0000, 32'h1, 1'b0);
        step();
        checks++; if (out_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_result got %h exp 7fffffff", out_result); end
        checks++; if ({out_co, out_ovf, out_zero} !== 3'b110) begin errors++; $display("FAIL sub_flags got %b exp 110", {out_co, out_ovf, out_zero}); end
        drive(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
        step();
        checks++; if ({out_valid, out_result, out_co, out_ovf} !== {1'b1, 32'h1, 2'b00}) begin errors++; $display("FAIL slt got v=%b %h co=%b ovf=%b exp v=1 00000001 co=0 ovf=0", out_valid, out_result, out_co, out_ovf); end
        drive(4'd7, 32'hFFFF_FFFF, 32'h0, 1'b0);
        step();
        checks++; if ({out_valid, out_result, out_zero} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL sltu got v=%b %h z=%b exp v=1 00000000 z=1", out_valid, out_result, out_zero); end
        drive(4'd3, 32'h0, 32'h0, 1'b0);
        step();
        checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL not_result got %h exp ffffffff", out_result); end
        drive(4'd13, 32'h1234_5678, 32'h9, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if ({out_result, out_err, out_zero} !== {32'h0, 2'b11}) begin errors++; $display("FAIL reserved got %h err=%b z=%b exp 00000000 err=1 z=1", out_result, out_err, out_zero); end
        step();
    endtask

    task automatic test_shift();
        drive(4'd10, 32'h8000_0000, 32'd36, 1'b0);
        step();
        checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h exp f8000000", out_result); end
        drive(4'd9, 32'h8000_0000, 32'd36, 1'b0);
        step();
        checks++; if (out_result !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h exp 08000000", out_result); end
        drive(4'd8, 32'h0000_0001, 32'd33, 1'b0);
        step();
        in_valid = 1'b0;
        checks++; if (out_result !== 32'h0000_0002) begin errors++; $display("FAIL sll got %h exp 00000002", out_result); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        step();
        drive(4'd1, 32'h1, 32'h2, 1'b0);
        checks++; if ({out_valid, out_result, in_ready} !== {1'b1, 32'hF000_F000, 1'b0}) begin errors++; $display("FAIL bp_first got v=%b %h rdy=%b exp v=1 f000f000 rdy=0", out_valid, out_result, in_ready); end
        step();
        step();
        checks++; if ({out_valid, out_result, in_ready} !== {1'b1, 32'hF000_F000, 1'b0}) begin errors++; $display("FAIL bp_hold got v=%b %h rdy=%b exp v=1 f000f000 rdy=0", out_valid, out_result, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_result} !== {1'b1, 32'h3}) begin errors++; $display("FAIL bp_second got v=%b %h exp v=1 00000003", out_valid, out_result); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_mul();
        int busy_cycles = 0;
        drive(4'd11, 32'h0001_0003, 32'h0000_0005, 1'b0);
        step();
        in_valid = 1'b0;
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h7;
`ifdef ALU_PIPE_MUL_EN
        for (int i = 0; i < 32; i++) begin
            if (busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0) busy_cycles++;
            if (i < 31) step();
        end
        checks++; if (busy_cycles != 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", busy_cycles); end
        step();
        checks++; if ({out_valid, busy, out_result, out_err} !== {2'b10, 32'h0005_000F, 1'b0}) begin errors++; $display("FAIL mul_result got v=%b busy=%b %h err=%b exp v=1 busy=0 0005000f err=0", out_valid, busy, out_result, out_err); end
`else
        busy_cycles = busy ? 1 : 0;
        checks++; if (busy_cycles != 0) begin errors++; $display("FAIL mul_off_busy got %0d exp 0", busy_cycles); end
        checks++; if ({out_valid, out_result, out_err} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL mul_off got v=%b %h err=%b exp v=1 00000000 err=1", out_valid, out_result, out_err); end
`endif
        step();
    endtask

    task automatic test_reset_mid_mul();
        int stale = 0;
`ifdef ALU_PIPE_MUL_EN
        drive(4'd11, 32'h0001_0003, 32'h0000_0005, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got %b exp 1", busy); end
`else
        out_ready = 1'b0;
        drive(4'd4, 32'h1, 32'h1, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        checks++; if (out_result !== 32'h2) begin errors++; $display("FAIL held_before_reset got %h exp 00000002", out_result); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, out_valid, out_result} !== {2'b00, 32'h0}) begin errors++; $display("FAIL mid_reset got busy=%b v=%b %h exp busy=0 v=0 00000000", busy, out_valid, out_result); end
        out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rdy got %b exp 1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
            step();
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL post_reset_stale got %0d exp 0", stale); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_shift();
        test_backpressure();
        test_mul();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 32-bit gate-level ALU. Replaces the decoder-plus-OR-merge datapath with an opcode-selected, flag-producing unit.
- Width is generic. Adds subtract, compare, shift and an iterative multiply.
- Sits between the register-file read stage and writeback; uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), localparam: shift-amount bits taken from in_b[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; transfer on in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B / shift amount.
- in_ci  in  1  carry-in, used by ADD only.
- in_op  in  4  opcode.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts; transfer on out_valid && out_ready.
- out_result  out  WIDTH  result.
- out_co  out  1  carry-out.
- out_zero  out  1  out_result == 0.
- out_ovf  out  1  signed overflow.
- out_err  out  1  reserved/disabled opcode.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Reset (async assert, sync release): all outputs and state are 0; FSM = IDLE. After release, in_ready = 1.
- Opcodes:
  - 0 AND; 1 OR; 2 XOR; 3 NOT A.
  - 4 ADD: a+b+ci.
  - 5 SUB: a+~b+1; co = 1 means no borrow.
  - 6 SLT signed; 7 SLTU. Result is 0 or 1, zero-extended.
  - 8 SLL; 9 SRL; 10 SRA. Shift amount is b[SHW-1:0]; upper bits of b are ignored.
  - 11 MUL: low WIDTH bits of the product.
  - 12-15 reserved: result 0, out_err = 1.
- Flags:
  - co and ovf are valid for ADD/SUB only; otherwise 0.
  - ovf = operand signs equal (B inverted for SUB) and result sign differs.
  - zero is computed for every opcode.
  - err = 0 except for reserved opcodes.
- Output stage: single-entry register. Result, flags and out_valid are stable while out_valid && !out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready), so a new op is accepted in the same cycle the old result is consumed.
- Single-cycle ops: accepted at edge T; out_valid = 1 after edge T. Back-to-back throughput is 1 op/cycle when out_ready = 1.
- FSM IDLE -> MUL on an accepted opcode 11 (macro enabled):
  - Load multiplicand and multiplier; clear accumulator; counter = WIDTH-1; busy = 1.
  - MUL state: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; decrement counter.
  - At counter == 0 after the final add: write the output register, return to IDLE, busy = 0. out_valid rises after edge T+WIDTH.
- MUL cannot finish while the output register is still full. It is accepted only when in_ready = 1, and in_ready stays low during MUL. The prior result, if any, was consumed at acceptance.
- in_a/in_b/in_op changes are ignored while busy or when not accepted.
- Reset mid-MUL: operation aborted; no out_valid; FSM = IDLE.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 11 runs the iterative multiplier as above.
- Undefined: no MUL state or multiplier datapath. Opcode 11 is treated as reserved: single-cycle, result 0, out_err = 1. busy is tied to 0.

Test Plan:
- ADD, a=0xFFFFFFFF, b=0x1, ci=0 -> out_valid after 1 edge; result 0x00000000, co=1, zero=1, ovf=0.
- SUB, a=0x80000000, b=0x1 -> 0x7FFFFFFF, co=1, ovf=1, zero=0. SLT with a=0xFFFFFFFF, b=0 -> 1. SLTU with the same operands -> 0.
- Backpressure: out_ready=0; AND 0xF0F0F0F0 & 0xFF00FF00 accepted -> 0xF000F000 held; in_ready=0; second op held. Raise out_ready -> second op accepted in the same cycle, result next edge.
- SRA a=0x80000000, b=36 -> 0xF8000000 (shift 4). SRL with the same operands -> 0x08000000.
- MUL 0x00010003 * 0x00000005 (macro on) -> busy=1 and in_ready=0 for 32 cycles; out_valid after edge T+32; result 0x0005000F. With the macro off -> result 0, out_err=1 after 1 edge.
- Drop rst_n 10 cycles into a MUL -> busy, out_valid and result are 0 immediately. After release, in_ready=1 and no stale result appears.
